// File: rtl/i2s_tdm_tx.sv
// i2s_tdm_tx: I2S / TDM serial audio transmitter with a one-frame holding buffer and gain shift.
// Define I2S_TDM_TX_HOLD_LAST_EN to repeat the last transmitted frame on underrun instead of silence.

module i2s_tdm_tx_lane #(
  parameter int DW = 24,
  parameter int SW = 6
) (
  input  logic [DW-1:0] din,
  input  logic [SW-1:0] shamt,
  output logic [DW-1:0] dout
);
  assign dout = $signed(din) >>> shamt;
endmodule

module i2s_tdm_tx #(
  parameter int DW       = 24,
  parameter int SLOT_W   = 32,
  parameter int NCH      = 2,
  parameter int FS_RATIO = 256,
  parameter int MODE     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH*DW-1:0]     s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [$clog2(DW):0]   gain_shift,
  output logic                  frame_req,
  output logic                  underrun,
  input  logic                  underrun_clr,
  output logic                  sclk,
  output logic                  lrclk,
  output logic                  sdo
);
  localparam int FRAME = NCH * SLOT_W;
  localparam int DIV   = FS_RATIO / FRAME;
  localparam int GW    = $clog2(DW) + 1;
  localparam int DCW   = $clog2(DIV);
  localparam int BCW   = $clog2(FRAME);

  logic [DCW-1:0]          div_cnt, div_nxt;
  logic [BCW-1:0]          bit_cnt, bit_nxt;
  logic [FRAME-1:0]        shreg, new_frame, load_frame, fallback;
  logic [NCH*DW-1:0]       hold_data;
  logic                    hold_vld;
  logic                    fall, boundary, accept, lr_nxt;
  logic [GW-1:0]           shamt;
  logic [NCH-1:0][DW-1:0]  scaled;

  assign fall     = (div_cnt == DCW'(DIV - 1));
  assign boundary = fall && (bit_cnt == BCW'(FRAME - 1));
  assign accept   = s_valid && s_ready;
  assign s_ready  = !hold_vld;
  assign div_nxt  = fall ? '0 : div_cnt + DCW'(1);
  assign bit_nxt  = boundary ? '0 : bit_cnt + BCW'(1);
  assign lr_nxt   = (MODE == 0) ? (bit_nxt >= BCW'(FRAME / 2)) : (bit_nxt == '0);
  assign shamt    = (gain_shift > GW'(DW - 1)) ? GW'(DW - 1) : gain_shift;

  // Each slot: DW scaled data bits MSB-first, then zero padding to SLOT_W.
  for (genvar c = 0; c < NCH; c++) begin : g_lane
    i2s_tdm_tx_lane #(.DW(DW), .SW(GW)) u_lane (
      .din   (hold_data[c*DW +: DW]),
      .shamt (shamt),
      .dout  (scaled[c])
    );
    if (SLOT_W > DW) begin : g_pad
      assign new_frame[FRAME-1-c*SLOT_W -: SLOT_W] = {scaled[c], {(SLOT_W-DW){1'b0}}};
    end else begin : g_nopad
      assign new_frame[FRAME-1-c*SLOT_W -: SLOT_W] = scaled[c];
    end
  end

`ifdef I2S_TDM_TX_HOLD_LAST_EN
  logic [FRAME-1:0] last_frame;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        last_frame <= '0;
    else if (boundary) last_frame <= load_frame;
  end
  assign fallback = last_frame;
`else
  assign fallback = '0;
`endif

  assign load_frame = hold_vld ? new_frame : fallback;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      bit_cnt   <= BCW'(FRAME - 1);
      sclk      <= 1'b0;
      sdo       <= 1'b0;
      lrclk     <= (MODE == 0);
      shreg     <= '0;
      hold_data <= '0;
      hold_vld  <= 1'b0;
      frame_req <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      div_cnt   <= div_nxt;
      sclk      <= (div_nxt >= DCW'(DIV / 2));
      frame_req <= boundary;
      // sdo takes the MSB before the shift, giving the one-bit delay after lrclk.
      if (fall) begin
        bit_cnt <= bit_nxt;
        sdo     <= shreg[FRAME-1];
        lrclk   <= lr_nxt;
        shreg   <= boundary ? load_frame : {shreg[FRAME-2:0], 1'b0};
      end
      // A same-cycle accept lands after the boundary has already sampled the empty buffer.
      if (accept) begin
        hold_data <= s_data;
        hold_vld  <= 1'b1;
      end else if (boundary) begin
        hold_vld  <= 1'b0;
      end
      if (boundary && !hold_vld) underrun <= 1'b1;
      else if (underrun_clr)     underrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Directed bench for i2s_tdm_tx: default I2S instance plus an 8-channel TDM instance.
module tb_i2s_tdm_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [47:0]  s_data = '0;
  logic         s_valid = 1'b0, underrun_clr = 1'b0;
  logic [5:0]   gain_shift = '0;
  logic         s_ready, frame_req, underrun, sclk, lrclk, sdo;
  logic [191:0] s_data_b = '0;
  logic         s_valid_b = 1'b0;
  logic         s_ready_b, frame_req_b, underrun_b, sclk_b, lrclk_b, sdo_b;

  int errors = 0, checks = 0, pos = 0;

  i2s_tdm_tx #(.DW(24), .SLOT_W(32), .NCH(2), .FS_RATIO(256), .MODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .gain_shift(gain_shift), .frame_req(frame_req), .underrun(underrun),
    .underrun_clr(underrun_clr), .sclk(sclk), .lrclk(lrclk), .sdo(sdo)
  );

  i2s_tdm_tx #(.DW(24), .SLOT_W(32), .NCH(8), .FS_RATIO(512), .MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_data(s_data_b), .s_valid(s_valid_b), .s_ready(s_ready_b),
    .gain_shift(6'd0), .frame_req(frame_req_b), .underrun(underrun_b),
    .underrun_clr(1'b0), .sclk(sclk_b), .lrclk(lrclk_b), .sdo(sdo_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] fr(input logic [23:0] l, input logic [23:0] r);
    return {l, 8'h00, r, 8'h00};
  endfunction

  function automatic logic [23:0] lv(input int i);
    return 24'h123456 + 24'(i) * 24'h010101;
  endfunction

  // Lands on the negedge inside the first clk of a frame (bit_cnt 0).
  task automatic wait_req();
    int t;
    t = 0;
    while (!frame_req && t < 600) begin @(negedge clk); t++; end
    chk("frame_req_wait", 64'(t < 600), 64'd1);
    pos = 0;
  endtask

  task automatic goto_k(input int k);
    if (pos < 4 * k) begin
      while (pos < 4 * k) begin @(posedge clk); pos++; end
      @(negedge clk);
    end
  endtask

  task automatic push(input logic [47:0] d);
    int t;
    t = 0;
    s_data = d; s_valid = 1'b1;
    while (!s_ready && t < 600) begin @(posedge clk); pos++; @(negedge clk); t++; end
    @(posedge clk); pos++;
    #1; s_valid = 1'b0; underrun_clr = 1'b0;
    @(negedge clk);
    chk("push_wait", 64'(t < 600), 64'd1);
  endtask

  task automatic capture(output logic [63:0] f, output logic [63:0] lr);
    wait_req();
    f = '0; lr = '0;
    lr[63] = lrclk;
    for (int k = 1; k <= 64; k++) begin
      goto_k(k);
      f[64-k] = sdo;
      if (k < 64) lr[63-k] = lrclk;
    end
    pos -= 256;
  endtask

  initial begin
    logic [7:0]  sc, fq;
    logic [63:0] f, lr, hold_exp;
    logic [23:0] l;
    int t, hi;
    logic s224, s225, s226;
    sc = '0; fq = '0; hi = 0; s224 = 1'b0; s225 = 1'b0; s226 = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_sclk", 64'(sclk), 64'd0);
    chk("rst_sdo", 64'(sdo), 64'd0);
    chk("rst_lrclk", 64'(lrclk), 64'd1);
    chk("rst_ready", 64'(s_ready), 64'd1);
    chk("rst_req", 64'(frame_req), 64'd0);
    chk("rst_underrun", 64'(underrun), 64'd0);
    rst_n = 1'b1;

    // Idle run: sclk period 4, first boundary on 4th clk, underrun after it
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); @(negedge clk);
      sc = {sc[6:0], sclk};
      fq = {fq[6:0], frame_req};
    end
    chk("sclk_pattern", 64'(sc), 64'h66);
    chk("req_pattern", 64'(fq), 64'h10);
    chk("first_underrun", 64'(underrun), 64'd1);
    wait_req();
    t = 0;
    do begin @(negedge clk); t++; end while (!frame_req && t < 400);
    chk("req_period", 64'(t), 64'd256);
    pos = 0;
    capture(f, lr);
    chk("idle_frame", f, 64'd0);
    chk("idle_lrclk", lr, 64'h00000000FFFFFFFF);

    // Basic frame, gain 0
    underrun_clr = 1'b1;
    push({24'h7FFFFF, 24'h800001});
    chk("ready_after_accept", 64'(s_ready), 64'd0);
    chk("underrun_cleared", 64'(underrun), 64'd0);
    capture(f, lr);
    chk("frame_basic", f, fr(24'h800001, 24'h7FFFFF));
    chk("frame_basic_lrclk", lr, 64'h00000000FFFFFFFF);
    chk("underrun_after_gap", 64'(underrun), 64'd1);
    chk("ready_after_boundary", 64'(s_ready), 64'd1);

    // Gain shift and clamping
    gain_shift = 6'd3; underrun_clr = 1'b1;
    push({24'h000000, 24'h800000});
    capture(f, lr);
    chk("gain3", f, fr(24'hF00000, 24'h000000));
    gain_shift = 6'd30; underrun_clr = 1'b1;
    push({24'h7FFFFF, 24'hFFFFFF});
    capture(f, lr);
    chk("gain_clamp", f, fr(24'hFFFFFF, 24'h000000));

    // Continuous stream, source answers frame_req promptly
    gain_shift = 6'd0; underrun_clr = 1'b1;
    push({~lv(0), lv(0)});
    for (int i = 0; i < 8; i++) begin
      wait_req();
      push({~lv(i + 1), lv(i + 1)});
      l = '0;
      for (int k = 1; k <= 24; k++) begin goto_k(k); l = {l[22:0], sdo}; end
      chk("stream_left", 64'(l), 64'(lv(i)));
      chk("stream_ready_low", 64'(s_ready), 64'd0);
      chk("stream_no_underrun", 64'(underrun), 64'd0);
    end

    // Mid-frame reset discards frame and held data
    wait_req();
    push({~lv(9), lv(9)});
    goto_k(40);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("midrst_sclk", 64'(sclk), 64'd0);
    chk("midrst_sdo", 64'(sdo), 64'd0);
    chk("midrst_lrclk", 64'(lrclk), 64'd1);
    chk("midrst_ready", 64'(s_ready), 64'd1);
    chk("midrst_req", 64'(frame_req), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    capture(f, lr);
    chk("post_rst_frame", f, 64'd0);
    chk("post_rst_underrun", 64'(underrun), 64'd1);

    // Skipped refill: silence or repeat of last frame
    underrun_clr = 1'b1;
    push({24'h00ABCD, 24'hC0FFEE});
    capture(f, lr);
    chk("frame_x", f, fr(24'hC0FFEE, 24'h00ABCD));
`ifdef I2S_TDM_TX_HOLD_LAST_EN
    hold_exp = fr(24'hC0FFEE, 24'h00ABCD);
`else
    hold_exp = 64'd0;
`endif
    capture(f, lr);
    chk("underrun_frame", f, hold_exp);
    chk("underrun_flag", 64'(underrun), 64'd1);

    // TDM instance: 8 ch, DIV=2, one-sclk fs pulse
    rst_n = 1'b0; #1;
    chk("b_rst_lrclk", 64'(lrclk_b), 64'd0);
    chk("b_rst_sclk", 64'(sclk_b), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    while (!frame_req_b && t < 1100) begin @(negedge clk); t++; end
    chk("b_req_wait1", 64'(t < 1100), 64'd1);
    s_data_b = '0;
    s_data_b[191:168] = 24'h800000;
    s_valid_b = 1'b1;
    @(posedge clk); #1; s_valid_b = 1'b0;
    @(negedge clk);
    t = 0;
    while (!frame_req_b && t < 1100) begin @(negedge clk); t++; end
    chk("b_req_wait2", 64'(t < 1100), 64'd1);
    for (int i = 0; i < 512; i++) begin
      if (lrclk_b) hi++;
      if (i == 448) s224 = sdo_b;
      if (i == 450) s225 = sdo_b;
      if (i == 452) s226 = sdo_b;
      @(negedge clk);
    end
    chk("b_fs_high_clks", 64'(hi), 64'd2);
    chk("b_bit224", 64'(s224), 64'd0);
    chk("b_ch7_msb", 64'(s225), 64'd1);
    chk("b_bit226", 64'(s226), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
